// File: rtl/ast_mux.sv
// ast_mux: Avalon-ST N-to-1 packet multiplexer with round-robin whole-packet arbitration
module ast_mux #(
  parameter int DATA_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 8,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int RX_DIR        = 4,
  parameter int DIR_SEL_WIDTH = RX_DIR == 1 ? 1 : $clog2(RX_DIR)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]      ast_data_i,
  input  logic [RX_DIR-1:0]                      ast_startofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_endofpacket_i,
  input  logic [RX_DIR-1:0]                      ast_valid_i,
  input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [RX_DIR-1:0]                      ast_ready_o,
  output logic [DATA_WIDTH-1:0]                  ast_data_o,
  output logic                                   ast_startofpacket_o,
  output logic                                   ast_endofpacket_o,
  output logic                                   ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]                 ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]               ast_channel_o,
  output logic [DIR_SEL_WIDTH-1:0]               dir_o,
  input  logic                                   ast_ready_i
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                   r_state;
  logic [DIR_SEL_WIDTH-1:0] r_rr, r_grant, r_dir;
  logic                     r_valid, r_sop, r_eop;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [EMPTY_WIDTH-1:0]   r_empty;
  logic [CHANNEL_WIDTH-1:0] r_channel;
  logic [RX_DIR-1:0]        w_elig;
  logic [DIR_SEL_WIDTH-1:0] w_sel, w_src, w_nxt;
  logic                     w_found, w_go, w_can_load, w_xfer;
  assign w_elig     = ast_valid_i & ast_startofpacket_i;
  assign w_can_load = !r_valid || ast_ready_i;
  assign w_src      = r_state == LOCKED ? r_grant : w_sel;
  assign w_go       = r_state == LOCKED || w_found;
  assign w_xfer     = w_go && w_can_load && ast_valid_i[w_src];
  assign w_nxt      = w_src == DIR_SEL_WIDTH'(RX_DIR-1) ? '0 : w_src + DIR_SEL_WIDTH'(1);
  assign ast_ready_o = (rst_n && w_go && w_can_load) ? RX_DIR'(1) << w_src : '0;
  assign ast_valid_o         = r_valid;
  assign ast_data_o          = r_data;
  assign ast_startofpacket_o = r_sop;
  assign ast_endofpacket_o   = r_eop;
  assign ast_empty_o         = r_empty;
  assign ast_channel_o       = r_channel;
  assign dir_o               = r_dir;
  // round-robin search: first eligible input at or above the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
    for (int i = 0; i < RX_DIR; i++) begin
      int idx;
      idx = (int'(r_rr) + i) % RX_DIR;
      if (!w_found && w_elig[DIR_SEL_WIDTH'(idx)]) begin
        w_found = 1'b1;
        w_sel   = DIR_SEL_WIDTH'(idx);
      end
    end
  end
  // output register stage plus packet lock / rr pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_empty   <= '0;
      r_channel <= '0;
      r_dir     <= '0;
    end else if (w_xfer) begin
      r_valid   <= 1'b1;
      r_data    <= ast_data_i[w_src];
      r_sop     <= ast_startofpacket_i[w_src];
      r_eop     <= ast_endofpacket_i[w_src];
      r_empty   <= ast_empty_i[w_src];
      r_channel <= ast_channel_i[w_src];
      r_dir     <= w_src;
      r_grant   <= w_src;
      r_state   <= ast_endofpacket_i[w_src] ? IDLE : LOCKED;
      r_rr      <= ast_endofpacket_i[w_src] ? w_nxt : r_rr;
    end else if (ast_ready_i) begin
      r_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ast_mux.sv
// tb_ast_mux: scoreboard and vector-table bench for the packet multiplexer
module tb_ast_mux;
  localparam int DW = 64, CW = 8, EW = 3, N = 4, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #10 clk = ~clk;
  logic [N-1:0][DW-1:0] data_i;
  logic [N-1:0]         sop_i, eop_i, valid_i, ready_o;
  logic [N-1:0][EW-1:0] empty_i;
  logic [N-1:0][CW-1:0] chan_i;
  logic [DW-1:0]        data_o;
  logic                 sop_o, eop_o, valid_o, ready_i;
  logic [EW-1:0]        empty_o;
  logic [CW-1:0]        chan_o;
  logic [SW-1:0]        dir_o;

  ast_mux dut (
    .clk(clk), .rst_n(rst_n),
    .ast_data_i(data_i), .ast_startofpacket_i(sop_i), .ast_endofpacket_i(eop_i),
    .ast_valid_i(valid_i), .ast_empty_i(empty_i), .ast_channel_i(chan_i),
    .ast_ready_o(ready_o), .ast_data_o(data_o), .ast_startofpacket_o(sop_o),
    .ast_endofpacket_o(eop_o), .ast_valid_o(valid_o), .ast_empty_o(empty_o),
    .ast_channel_o(chan_o), .dir_o(dir_o), .ast_ready_i(ready_i)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] chan;
    logic [SW-1:0] dir;
  } beat_t;
  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] s;
    logic         r;
    logic [N-1:0] e;
  } vec_t;

  beat_t src_q[N][$];
  beat_t exp_q[$];
  beat_t prev_b;
  logic  prev_hold;
  int    checks = 0, fails = 0, cyc = 0, first_in = -1, last_out = -1;
  int    first_x[N], last_x[N];
  logic [N-1:0] r;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  function automatic beat_t out_b();
    return {data_o, sop_o, eop_o, empty_o, chan_o, dir_o};
  endfunction

  function automatic int pending();
    int s = exp_q.size();
    for (int k = 0; k < N; k++) s += src_q[k].size();
    return s;
  endfunction

  task automatic add_pkt(input int k, input int n, input logic [CW-1:0] ch);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data  = {$urandom, $urandom};
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.empty = (i == n - 1) ? EW'(k + 1) : '0;
      b.chan  = ch;
      b.dir   = SW'(k);
      src_q[k].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic step(input logic rdy, output logic [N-1:0] ro);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        data_i[k]  = src_q[k][0].data;
        sop_i[k]   = src_q[k][0].sop;
        eop_i[k]   = src_q[k][0].eop;
        empty_i[k] = src_q[k][0].empty;
        chan_i[k]  = src_q[k][0].chan;
        valid_i[k] = 1'b1;
      end else begin
        data_i[k] = '0; sop_i[k] = 1'b0; eop_i[k] = 1'b0;
        empty_i[k] = '0; chan_i[k] = '0; valid_i[k] = 1'b0;
      end
    end
    ready_i = rdy;
    #8;
    ro = ready_o;
    if (prev_hold) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_fields", out_b(), prev_b);
    end
    if (valid_o && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_beat got=%0h exp=none", out_b());
      end else begin
        chk("beat", out_b(), exp_q.pop_front());
        last_out = cyc;
      end
    end
    prev_hold = valid_o && !rdy;
    prev_b    = out_b();
    for (int k = 0; k < N; k++)
      if (valid_i[k] && ready_o[k]) begin
        void'(src_q[k].pop_front());
        if (first_in < 0) first_in = cyc;
        if (first_x[k] < 0) first_x[k] = cyc;
        last_x[k] = cyc;
      end
    cyc++;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (pending() > 0 && n < 200) begin
      step(1'b1, r);
      n++;
    end
    chk(nm, pending(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    valid_i = '0; sop_i = '0; eop_i = '0; data_i = '0; empty_i = '0; chan_i = '0;
    ready_i = 1'b1;
    prev_hold = 1'b0;
    first_in = -1;
    last_out = -1;
    for (int k = 0; k < N; k++) begin first_x[k] = -1; last_x[k] = -1; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [N-1:0] bp_rdy, bp_exp;
    vt[0] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};
    vt[1] = '{4'b0100, 4'b0100, 1'b1, 4'b0100};
    vt[2] = '{4'b1111, 4'b1110, 1'b0, 4'b0010};
    vt[3] = '{4'b1010, 4'b1010, 1'b1, 4'b0010};
    vt[4] = '{4'b1000, 4'b1000, 1'b1, 4'b1000};
    vt[5] = '{4'b0001, 4'b0000, 1'b1, 4'b0000};
    vt[6] = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
    prev_hold = 1'b0;
    data_i = '0; eop_i = '0; empty_i = '0; chan_i = '0;
    valid_i = '1; sop_i = '1; ready_i = 1'b1;
    #5;
    chk("reset_outputs", {ready_o, out_b(), valid_o}, 0);
    @(negedge clk);
    valid_i = '0; sop_i = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      valid_i = vt[i].v; sop_i = vt[i].s; ready_i = vt[i].r;
      #1;
      chk($sformatf("arb_vec%0d", i), ready_o, vt[i].e);
    end
    valid_i = '0; sop_i = '0;

    do_reset();
    add_pkt(2, 3, 8'd5);
    drain("t1_drain");
    chk("t1_latency", last_out - first_in, 3);

    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N; k++) add_pkt(k, 2, CW'(16 * k + p));
    drain("t2_drain");
    chk("t2_rate", last_out - first_in, 16);

    do_reset();
    add_pkt(1, 4, 8'd3);
    bp_rdy = 4'b1001;
    bp_exp = 4'b1001;
    for (int t = 0; t < 7; t++) begin
      step(t < 4 ? bp_rdy[t] : 1'b1, r);
      chk($sformatf("t3_ready_c%0d", t), r, (t < 4 ? bp_exp[t] : (t < 6 ? 1'b1 : 1'b0)) ? 4'b0010 : 4'b0000);
    end
    chk("t3_drain", pending(), 0);

    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 1, CW'(p));
      add_pkt(3, 1, CW'(p + 8));
    end
    drain("t4_drain");
    chk("t4_rate", last_out - first_in, 8);

    do_reset();
    add_pkt(0, 4, 8'd1);
    add_pkt(1, 2, 8'd2);
    for (int n = 0; pending() > 0 && n < 200; n++) begin
      logic busy;
      busy = src_q[0].size() > 0;
      step(1'b1, r);
      if (busy) chk("t5_lock_r1", r[1], 0);
    end
    chk("t5_drain", pending(), 0);
    chk("t5_next", first_x[1], last_x[0] + 1);

    do_reset();
    add_pkt(2, 3, 8'd7);
    step(1'b1, r);
    step(1'b1, r);
    @(posedge clk);
    #2;
    chk("t6_pre_valid", valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", valid_o, 0);
    chk("t6_ready", ready_o, 0);
    do_reset();
    add_pkt(3, 2, 8'd9);
    drain("t6_drain");
    chk("t6_first", first_x[3] >= 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ast_mux.md
Name: ast_mux

Overview:
- Avalon-ST N-to-1 packet multiplexer. It is the merge-side counterpart of the ast demultiplexer.
- Accepts RX_DIR independent input streams and arbitrates whole packets round-robin onto one output stream.
- Reports the source index on dir_o.
- Sits upstream of shared sinks, for example re-merging demultiplexed traffic.

Parameters:
DATA_WIDTH, 64, data bus width in bits (multiple of 8)
CHANNEL_WIDTH, 8, channel field width
EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width
RX_DIR, 4, number of input streams (>=1)
DIR_SEL_WIDTH, RX_DIR==1 ? 1 : $clog2(RX_DIR), source index width

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
ast_data_i  input  RX_DIR x DATA_WIDTH  per-input data
ast_startofpacket_i  input  RX_DIR  per-input SOP
ast_endofpacket_i  input  RX_DIR  per-input EOP
ast_valid_i  input  RX_DIR  per-input valid
ast_empty_i  input  RX_DIR x EMPTY_WIDTH  per-input empty byte count
ast_channel_i  input  RX_DIR x CHANNEL_WIDTH  per-input channel
ast_ready_o  output  RX_DIR  per-input ready
ast_data_o  output  DATA_WIDTH  output data
ast_startofpacket_o  output  1  output SOP
ast_endofpacket_o  output  1  output EOP
ast_valid_o  output  1  output valid
ast_empty_o  output  EMPTY_WIDTH  output empty
ast_channel_o  output  CHANNEL_WIDTH  output channel (passed through)
dir_o  output  DIR_SEL_WIDTH  index of input that sourced the current output beat
ast_ready_i  input  1  downstream ready

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0, including ast_ready_o and ast_valid_o.
  - FSM = IDLE, rr pointer = 0, grant = 0.
- Transfer rules:
  - An input beat transfers when ast_valid_i[k] && ast_ready_o[k].
  - An output beat transfers when ast_valid_o && ast_ready_i.
- Output stage:
  - One register stage. can_load = !ast_valid_o || ast_ready_i.
  - Latency from input transfer to ast_valid_o is 1 cycle.
  - Full throughput: one beat per cycle under continuous ready.
  - Output fields (data, sop, eop, empty, channel, dir) change only on load; they are stable while valid && !ready.
  - ast_valid_o clears on output transfer when no new load occurs.
- FSM IDLE:
  - Eligible inputs are those with valid && startofpacket.
  - Select the first eligible index searching upward from the rr pointer, wrapping modulo RX_DIR.
  - ast_ready_o[sel] = can_load (combinational, same cycle); all other ready bits = 0.
  - On transfer of a beat without EOP: grant <= sel, go to LOCKED.
  - On transfer of a beat with EOP (single-beat packet): stay in IDLE, rr <= sel+1 mod RX_DIR.
  - No eligible input: nothing transfers.
- FSM LOCKED:
  - ast_ready_o[grant] = can_load; all other ready bits = 0.
  - Other inputs stall, with no loss and no reordering.
  - On transfer of an EOP beat: go to IDLE, rr <= grant+1 mod RX_DIR. The next packet may start on the following cycle, so there is no bubble beyond arbitration.
  - A SOP seen mid-packet on the granted input is forwarded as-is; it is an upstream error and does not cause re-arbitration.
- Protocol error, input in IDLE: valid without SOP is not eligible and is held (ready low) indefinitely. This is an upstream error.
- Ready/valid dependency:
  - ast_ready_o depends combinationally on ast_ready_i and on input valid/SOP.
  - ast_valid_o never depends combinationally on ast_ready_i.
- rr pointer wraps from RX_DIR-1 to 0.
- RX_DIR=1: pass-through with 1-cycle latency; dir_o always 0.
- Reset mid-packet: the partial packet is abandoned and the output valid drops immediately. Upstream must restart from SOP.

Test Plan:
- Single input: input 2 sends 3-beat packet (D0..D2, channel 5) with ready_i=1 -> identical beats out 1 cycle later, sop on D0, eop on D2, channel_o=5, dir_o=2, no gaps.
- Fairness: all 4 inputs hold 2-beat packets from reset -> output order is inputs 0,1,2,3,0,..., each packet contiguous, never interleaved.
- Backpressure: ready_i toggles 1,0,0,1 during 4-beat packet from input 1 -> ast_ready_o[1] follows can_load, output fields stable while stalled, all 4 beats delivered once, in order.
- Single-beat packets: inputs 0 and 3 both send sop&eop beats every cycle -> alternating dir_o 0,3,0,3 at full rate.
- Lock: input 0 mid-packet while input 1 raises valid+sop -> ast_ready_o[1]=0 until input 0's eop transfers; input 1's packet starts the next cycle.
- Reset: assert rst_n=0 mid-packet -> ast_valid_o=0 and all ast_ready_o=0 immediately. After release, a new packet on input 3 arbitrates with rr=0 and dir_o=3.
